// File: rtl/doa_peak_search_pkg.sv
// Shared types and defaults for the DOA peak-search block.
package doa_peak_search_pkg;

  // Encodings are fixed so that they match the beamformer and the steering-vector sequencer.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } doa_state_e;

  localparam int DOA_WORD_LENGTH_DEF = 32;
  localparam int DOA_N_ANGLES_DEF    = 181;
  localparam int DOA_LOG2_INTEG_DEF  = 2;

  // Index width for a count of n items. It never returns zero, so a one-entry table still gets a real port.
  function automatic int doa_idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/doa_acc_ram.sv
// Per-angle accumulator store: asynchronous read port, synchronous write port with enable.
module doa_acc_ram #(
  parameter int DEPTH = 181,
  parameter int AW    = 8,
  parameter int DW    = 34
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  // Write port: the contents are never cleared, because the first sweep of every estimate overwrites them.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/doa_peak_search.sv
// Integrates 2**LOG2_INTEG beam-power sweeps per steering angle.
// It reports the angle with the highest integrated power and the mean power at that angle.
module doa_peak_search
  import doa_peak_search_pkg::*;
#(
  parameter int WORD_LENGTH_IN = DOA_WORD_LENGTH_DEF,
  parameter int N_ANGLES       = DOA_N_ANGLES_DEF,
  parameter int ANGLE_W        = doa_idx_width(N_ANGLES),
  parameter int LOG2_INTEG     = DOA_LOG2_INTEG_DEF,
  parameter int ACC_W          = WORD_LENGTH_IN + LOG2_INTEG
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WORD_LENGTH_IN-1:0] in_power,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ANGLE_W-1:0]        out_angle,
  output logic [WORD_LENGTH_IN-1:0] out_power
);

  localparam int                   SWP_W    = (LOG2_INTEG > 0) ? LOG2_INTEG : 1;
  localparam logic [ANGLE_W-1:0]   ANG_LAST = ANGLE_W'(N_ANGLES - 1);
  localparam logic [SWP_W-1:0]     SWP_LAST = SWP_W'((1 << LOG2_INTEG) - 1);

  doa_state_e state_q, state_d;

  logic [ANGLE_W-1:0]        ang_cnt_q, ang_cnt_d;
  logic [SWP_W-1:0]          swp_cnt_q, swp_cnt_d;
  logic [ACC_W-1:0]          best_q, best_d;
  logic [ANGLE_W-1:0]        best_idx_q, best_idx_d;
  logic [ANGLE_W-1:0]        out_angle_q, out_angle_d;
  logic [WORD_LENGTH_IN-1:0] out_power_q, out_power_d;

  logic             accept;
  logic             last_ang;
  logic             first_sweep;
  logic             last_sweep;
  logic             final_sample;
  logic             take_peak;
  logic [ACC_W-1:0] in_ext;
  logic [ACC_W-1:0] rd_data;
  logic [ACC_W-1:0] sum;
  logic [ACC_W-1:0] mean;

  // Sample handshake and sweep-position decode.
  always_comb begin
    accept       = in_valid && (state_q == RUN);
    last_ang     = (ang_cnt_q == ANG_LAST);
    first_sweep  = (swp_cnt_q == '0);
    last_sweep   = (swp_cnt_q == SWP_LAST);
    final_sample = accept && last_sweep && last_ang;
  end

  // Read-modify-write sum. The first sweep ignores the stale RAM word.
  always_comb begin
    in_ext = ACC_W'(in_power);
    sum    = first_sweep ? in_ext : (rd_data + in_ext);
  end

  doa_acc_ram #(
    .DEPTH (N_ANGLES),
    .AW    (ANGLE_W),
    .DW    (ACC_W)
  ) u_acc_ram (
    .clk_i   (clk),
    .we_i    (accept),
    .waddr_i (ang_cnt_q),
    .wdata_i (sum),
    .raddr_i (ang_cnt_q),
    .rdata_o (rd_data)
  );

  // Peak tracking on the final sweep. A strict compare keeps the lowest index on ties.
  // The result registers are loaded from the same next-state values, so that the last angle
  // takes part in the final pick.
  always_comb begin
    take_peak   = accept && last_sweep && ((ang_cnt_q == '0) || (sum > best_q));
    best_d      = take_peak ? sum : best_q;
    best_idx_d  = take_peak ? ang_cnt_q : best_idx_q;
    mean        = best_d >> LOG2_INTEG;
    out_angle_d = out_angle_q;
    out_power_d = out_power_q;
    if (final_sample) begin
      out_angle_d = best_idx_d;
      out_power_d = WORD_LENGTH_IN'(mean);
    end
  end

  // Angle and sweep counters. They clear on entry to RUN and advance only on accepted samples.
  always_comb begin
    ang_cnt_d = ang_cnt_q;
    swp_cnt_d = swp_cnt_q;
    if ((state_q == IDLE) && start) begin
      ang_cnt_d = '0;
      swp_cnt_d = '0;
    end else if (accept) begin
      if (last_ang) begin
        ang_cnt_d = '0;
        swp_cnt_d = swp_cnt_q + 1'b1;
      end else begin
        ang_cnt_d = ang_cnt_q + 1'b1;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ang_cnt_q   <= '0;
      swp_cnt_q   <= '0;
      best_q      <= '0;
      best_idx_q  <= '0;
      out_angle_q <= '0;
      out_power_q <= '0;
    end else begin
      ang_cnt_q   <= ang_cnt_d;
      swp_cnt_q   <= swp_cnt_d;
      best_q      <= best_d;
      best_idx_q  <= best_idx_d;
      out_angle_q <= out_angle_d;
      out_power_q <= out_power_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state. A start pulse that arrives together with the HOLD handshake is dropped.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (final_sample) state_d = HOLD;
      HOLD:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy      = (state_q == RUN) || (state_q == HOLD);
    in_ready  = (state_q == RUN);
    out_valid = (state_q == HOLD);
    out_angle = out_angle_q;
    out_power = out_power_q;
  end

endmodule

// File: tb/tb_doa_peak_search.sv
// Randomized self-checking bench for doa_peak_search (N_ANGLES=8, LOG2_INTEG=2, WORD_LENGTH_IN=32).
module tb_doa_peak_search;

  localparam int NA = 8;
  localparam int L2 = 2;
  localparam int WL = 32;
  localparam int NS = NA * (1 << L2);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy;
  logic          in_valid;
  logic          in_ready;
  logic [WL-1:0] in_power;
  logic          out_valid;
  logic          out_ready;
  logic [2:0]    out_angle;
  logic [WL-1:0] out_power;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  doa_peak_search #(
    .WORD_LENGTH_IN (WL),
    .N_ANGLES       (NA),
    .LOG2_INTEG     (L2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_power  (in_power),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_angle (out_angle),
    .out_power (out_power)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: counts accepted samples, sums them per angle and picks the argmax.
  typedef enum int {M_IDLE, M_RUN, M_HOLD} mstate_t;
  mstate_t         ms = M_IDLE;
  int              ncnt = 0;
  longint unsigned macc [NA];
  logic [2:0]      m_angle = '0;
  logic [WL-1:0]   m_power = '0;

  always @(posedge clk) begin
    if (rst) begin
      ms = M_IDLE; ncnt = 0; m_angle = '0; m_power = '0;
    end else begin
      case (ms)
        M_IDLE: if (start) begin ms = M_RUN; ncnt = 0; end
        M_RUN: if (in_valid) begin
          if (ncnt < NA) macc[ncnt % NA] = longint'(in_power);
          else           macc[ncnt % NA] += longint'(in_power);
          ncnt++;
          if (ncnt == NS) begin
            longint unsigned best;
            logic [63:0]     mean;
            int              bi;
            best = macc[0]; bi = 0;
            for (int i = 1; i < NA; i++) if (macc[i] > best) begin best = macc[i]; bi = i; end
            mean    = best >> L2;
            m_angle = 3'(bi);
            m_power = mean[WL-1:0];
            ms      = M_HOLD;
          end
        end
        M_HOLD: if (out_ready) ms = M_IDLE;
        default: ms = M_IDLE;
      endcase
    end
  end

  // Every-cycle comparison against the model, taken on the falling edge.
  always @(negedge clk) begin
    chk("busy",      {63'd0, busy},      {63'd0, ms != M_IDLE});
    chk("in_ready",  {63'd0, in_ready},  {63'd0, ms == M_RUN});
    chk("out_valid", {63'd0, out_valid}, {63'd0, ms == M_HOLD});
    chk("out_angle", {61'd0, out_angle}, {61'd0, m_angle});
    chk("out_power", {32'd0, out_power}, {32'd0, m_power});
  end

  logic [WL-1:0] samples [NS];

  task automatic fill(input int mode);
    for (int k = 0; k < NS; k++) begin
      int a;
      int s;
      a = k % NA;
      s = k / NA;
      case (mode)
        1: samples[k] = WL'(100 * (a + 1));
        2: samples[k] = (a == 2 || a == 6) ? 32'd9 : 32'd5;
        3: samples[k] = (s == 0) ? ((a == 1) ? 32'd1000 : 32'd0) : ((a == 4) ? 32'd500 : 32'd0);
        5: samples[k] = 32'hFFFF_FFFF;
        7: samples[k] = $urandom;
        default: samples[k] = WL'($urandom_range(0, 3));
      endcase
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drive(input int gap_pct, input int stop_at, input bit noise_start);
    int  idx;
    int  cyc;
    bit  rdy;
    idx = 0;
    cyc = 0;
    while (idx < stop_at && cyc < 4000) begin
      in_valid = ($urandom_range(0, 99) >= gap_pct);
      in_power = samples[idx];
      start    = noise_start && ($urandom_range(0, 7) == 0);
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      if (in_valid && rdy) idx++;
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    chk("drive_budget", 64'(idx), 64'(stop_at));
  endtask

  task automatic pin(input string name, input logic [2:0] ea, input logic [WL-1:0] ep);
    chk({name, "_model_angle"}, {61'd0, m_angle},   {61'd0, ea});
    chk({name, "_model_power"}, {32'd0, m_power},   {32'd0, ep});
    chk({name, "_dut_angle"},   {61'd0, out_angle}, {61'd0, ea});
    chk({name, "_dut_power"},   {32'd0, out_power}, {32'd0, ep});
    chk({name, "_dut_valid"},   {63'd0, out_valid}, 64'd1);
  endtask

  task automatic finish_out(input int low_cycles, input bit start_with_ready, input bit noise_start);
    out_ready = 1'b0;
    repeat (low_cycles) begin
      start = noise_start && ($urandom_range(0, 3) == 0);
      @(posedge clk); #1;
    end
    start     = start_with_ready;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    start     = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_power = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Ramp: the peak is at the last angle.
    fill(1); pulse_start(); drive(0, NS, 1'b0);
    pin("ramp", 3'd7, 32'd800);
    finish_out(0, 1'b0, 1'b0);

    // Ties resolve to the lowest index.
    fill(2); pulse_start(); drive(20, NS, 1'b0);
    pin("tie", 3'd2, 32'd9);
    finish_out(2, 1'b0, 1'b0);

    // The peak comes from the integrated value, not from the single-sweep maximum.
    fill(3); pulse_start(); drive(10, NS, 1'b0);
    pin("integ", 3'd4, 32'd375);
    finish_out(1, 1'b0, 1'b0);

    // Input gaps, stray start pulses, long back-pressure, then a start coincident with the accept.
    fill(1); pulse_start(); drive(30, NS, 1'b1);
    pin("gaps", 3'd7, 32'd800);
    finish_out(10, 1'b1, 1'b1);

    // Full-scale input with no overflow.
    fill(5); pulse_start(); drive(0, NS, 1'b0);
    pin("ovf", 3'd0, 32'hFFFF_FFFF);
    finish_out(0, 1'b0, 1'b0);

    // Reset partway through sweep 2, then a clean estimate.
    fill(1); pulse_start(); drive(15, 2 * NA + 3, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    pulse_start(); drive(15, NS, 1'b0);
    pin("rst_mid", 3'd7, 32'd800);
    finish_out(3, 1'b0, 1'b0);

    // Random estimates: wide values, then narrow values that produce many ties.
    for (int r = 0; r < 6; r++) begin
      fill((r < 3) ? 7 : 8);
      pulse_start();
      drive(25, NS, 1'b1);
      finish_out($urandom_range(0, 6), (r % 2) == 1, 1'b1);
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
